// File: rtl/credits_text_render_if.sv
// Character-ROM / font-ROM bus between the credits renderer (master) and the ROMs (slave).
interface credits_text_render_if;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_line;

  modport master (output char_xy, font_addr, input char_code, font_line);
  modport slave  (input char_xy, font_addr, output char_code, font_line);
endinterface

// File: rtl/credits_text_render.sv
// Scrolling credits overlay: 3-stage pixel pipeline (char ROM -> font ROM -> composite),
// text window scrolled bottom-to-top one line every SCROLL_DIV frames.
//   state | meaning
//   IDLE  | overlay off, scroll position and frame counter held at 0
//   RUN   | overlay drawn, scroll advances on vblank rising edges
module credits_text_render #(
  parameter int          TEXT_X     = 448,
  parameter int          TEXT_Y     = 200,
  parameter int          WIN_H      = 128,
  parameter int          ROWS       = 6,
  parameter int          SCROLL_DIV = 2,
  parameter logic [11:0] TEXT_RGB   = 12'hfff
) (
  input  logic                         pclk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [10:0]                  hcount_in,
  input  logic [10:0]                  vcount_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         hblnk_in,
  input  logic                         vblnk_in,
  input  logic [11:0]                  rgb_in,
  credits_text_render_if.master        rom,
  output logic [10:0]                  hcount_out,
  output logic [10:0]                  vcount_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic                         hblnk_out,
  output logic                         vblnk_out,
  output logic [11:0]                  rgb_out,
  output logic                         scroll_wrap
);
  localparam int TEXT_H     = ROWS * 16;
  localparam int SCROLL_MAX = WIN_H + TEXT_H - 1;
  localparam int FC_W       = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } timing_t;

  state_t              state_q, state_d;
  logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [8:0]          scroll_pos_q, scroll_pos_d;
  logic                scroll_wrap_q, scroll_wrap_d;
  logic [7:0]          char_xy_q, char_xy_d;
  logic [3:0]          line_q, line_d;
  logic [2:0]          bit1_q, bit1_d, bit2_q, bit2_d;
  logic                draw1_q, draw1_d, draw2_q, draw2_d;
  logic [11:0]         rgb1_q, rgb1_d, rgb2_q, rgb2_d, rgb_out_q, rgb_out_d;
  timing_t [2:0]       tim_q, tim_d;

  logic signed [11:0]  hx, vy;
  logic                in_win, in_text, frame_tick;

  always_comb begin
    state_d       = enable ? RUN : IDLE;
    frame_cnt_d   = frame_cnt_q;
    scroll_pos_d  = scroll_pos_q;
    scroll_wrap_d = 1'b0;
    // tim_q[0].vb is vblnk_in one cycle ago, doubling as the edge detector
    frame_tick    = vblnk_in & ~tim_q[0].vb;

    if (state_q == IDLE) begin
      frame_cnt_d  = '0;
      scroll_pos_d = '0;
    end else if (frame_tick) begin
      if (frame_cnt_q == FC_W'(SCROLL_DIV - 1)) begin
        frame_cnt_d = '0;
        if (scroll_pos_q == 9'(SCROLL_MAX)) begin
          scroll_pos_d  = '0;
          scroll_wrap_d = 1'b1;
        end else begin
          scroll_pos_d = scroll_pos_q + 9'd1;
        end
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end

    hx      = {1'b0, hcount_in} - 12'(TEXT_X);
    vy      = {1'b0, vcount_in} - 12'(TEXT_Y) + {3'b000, scroll_pos_q} - 12'(WIN_H);
    in_win  = !hx[11] && (hx < 12'sd128) &&
              (vcount_in >= 11'(TEXT_Y)) && (vcount_in < 11'(TEXT_Y + WIN_H));
    in_text = in_win && !vy[11] && (vy < $signed(12'(TEXT_H)));

    draw1_d   = in_text && (state_q == RUN);
    char_xy_d = draw1_d ? {vy[7:4], hx[6:3]} : 8'h00;
    line_d    = vy[3:0];
    bit1_d    = hx[2:0];
    rgb1_d    = rgb_in;
    tim_d[0]  = '{h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in,
                  hb: hblnk_in, vb: vblnk_in};

    bit2_d    = bit1_q;
    draw2_d   = draw1_q;
    rgb2_d    = rgb1_q;
    tim_d[1]  = tim_q[0];

    rgb_out_d = (draw2_q && rom.font_line[3'd7 - bit2_q]) ? TEXT_RGB : rgb2_q;
    tim_d[2]  = tim_q[1];
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      scroll_pos_q  <= '0;
      scroll_wrap_q <= 1'b0;
      char_xy_q     <= '0;
      line_q        <= '0;
      bit1_q        <= '0;
      bit2_q        <= '0;
      draw1_q       <= 1'b0;
      draw2_q       <= 1'b0;
      rgb1_q        <= '0;
      rgb2_q        <= '0;
      rgb_out_q     <= '0;
      tim_q         <= '0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      scroll_pos_q  <= scroll_pos_d;
      scroll_wrap_q <= scroll_wrap_d;
      char_xy_q     <= char_xy_d;
      line_q        <= line_d;
      bit1_q        <= bit1_d;
      bit2_q        <= bit2_d;
      draw1_q       <= draw1_d;
      draw2_q       <= draw2_d;
      rgb1_q        <= rgb1_d;
      rgb2_q        <= rgb2_d;
      rgb_out_q     <= rgb_out_d;
      tim_q         <= tim_d;
    end
  end

  assign rom.char_xy   = char_xy_q;
  assign rom.font_addr = {rom.char_code, line_q};

  assign hcount_out  = tim_q[2].h;
  assign vcount_out  = tim_q[2].v;
  assign hsync_out   = tim_q[2].hs;
  assign vsync_out   = tim_q[2].vs;
  assign hblnk_out   = tim_q[2].hb;
  assign vblnk_out   = tim_q[2].vb;
  assign rgb_out     = rgb_out_q;
  assign scroll_wrap = scroll_wrap_q;
endmodule

// File: tb/tb_credits_text_render.sv
// Randomised bench for credits_text_render against a pixel-level reference of the overlay rules.
module tb_credits_text_render;
  localparam int TEXT_X = 448, TEXT_Y = 200, WIN_H = 128, ROWS = 6, SCROLL_DIV = 2;
  localparam int SCROLL_MAX = WIN_H + ROWS * 16 - 1;

  logic        pclk, rst_n, enable;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic        scroll_wrap;

  credits_text_render_if rom_if ();

  credits_text_render dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rom(rom_if),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .scroll_wrap(scroll_wrap)
  );

  logic [6:0] char_mem [256];
  logic [7:0] font_mem [2048];

  assign rom_if.char_code = char_mem[rom_if.char_xy];
  always @(posedge pclk) rom_if.font_line <= font_mem[rom_if.font_addr];

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [11:0] rgb;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
  } exp_t;

  exp_t       p [3];
  logic [7:0] e_cxy;
  logic       e_wrap;
  int         m_sp, m_fc;
  bit         m_run, m_prev_vb;
  int         n_checks, n_errors, wrap_seen, fff_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: evaluates each pixel straight from window/scroll arithmetic and ROM contents.
  task automatic model_edge();
    exp_t       e;
    int         hx, vy;
    bit         in_text;
    logic [7:0] cxy, gl;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) p[i] = '0;
      m_sp = 0; m_fc = 0; m_run = 0; m_prev_vb = 0; e_cxy = '0; e_wrap = 0;
      return;
    end
    hx = int'(hcount_in) - TEXT_X;
    vy = int'(vcount_in) - TEXT_Y + m_sp - WIN_H;
    in_text = hx >= 0 && hx < 128 && int'(vcount_in) >= TEXT_Y && int'(vcount_in) < TEXT_Y + WIN_H
              && vy >= 0 && vy < ROWS * 16;
    e = '{rgb: rgb_in, h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in,
          hb: hblnk_in, vb: vblnk_in};
    e_cxy = '0;
    if (in_text && m_run) begin
      cxy   = 8'((vy / 16) * 16 + hx / 8);
      e_cxy = cxy;
      gl    = font_mem[{char_mem[cxy], 4'(vy % 16)}];
      if (gl[7 - hx % 8]) e.rgb = 12'hfff;
    end
    p[2] = p[1]; p[1] = p[0]; p[0] = e;
    e_wrap = 0;
    if (m_run) begin
      if (vblnk_in && !m_prev_vb) begin
        if (m_fc == SCROLL_DIV - 1) begin
          m_fc = 0;
          if (m_sp == SCROLL_MAX) begin m_sp = 0; e_wrap = 1; end
          else m_sp++;
        end else m_fc++;
      end
    end else begin
      m_sp = 0; m_fc = 0;
    end
    m_prev_vb = vblnk_in;
    m_run     = enable;
  endtask

  task automatic cycle(input logic [10:0] hc, input logic [10:0] vc,
                       input logic [11:0] rgb, input logic vb);
    hcount_in = hc; vcount_in = vc; rgb_in = rgb; vblnk_in = vb;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom); hblnk_in = 1'($urandom);
    @(posedge pclk);
    model_edge();
    #1;
    check("rgb", 32'(rgb_out), 32'(p[2].rgb));
    check("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'({p[2].h, p[2].v, p[2].hs, p[2].vs, p[2].hb, p[2].vb}));
    check("char_xy", 32'(rom_if.char_xy), 32'(e_cxy));
    check("wrap", 32'(scroll_wrap), 32'(e_wrap));
    if (scroll_wrap) wrap_seen++;
    if (rgb_out == 12'hfff) fff_seen++;
  endtask

  task automatic rnd_cycle(input logic vb);
    cycle(11'($urandom_range(440, 590)), 11'($urandom_range(195, 335)),
          12'($urandom_range(0, 12'hffe)), vb);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      rnd_cycle(1'b1);
      rnd_cycle(1'b0);
    end
  endtask

  initial begin
    logic [10:0] first_hc;
    n_checks = 0; n_errors = 0; wrap_seen = 0; fff_seen = 0;
    for (int i = 0; i < 256; i++) char_mem[i] = 7'($urandom);
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    char_mem[3] = 7'h43;
    font_mem[11'h430] = 8'h80;

    rst_n = 1'b0; enable = 1'b0;
    for (int i = 0; i < 3; i++) rnd_cycle(1'b0);
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_hcount", 32'(hcount_out), 32'h0);
    check("rst_char_xy", 32'(rom_if.char_xy), 32'h0);

    // scroll_pos 0: whole window is above the text, pure pass-through
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < 300; i++) rnd_cycle(1'b0);

    // 256 frames -> 128 scroll steps, text row 0 sits on the window top line
    frames(256);
    cycle(11'd472, 11'd200, 12'h123, 1'b0);
    check("dir_char_xy", 32'(rom_if.char_xy), 32'h03);
    check("dir_font_addr", 32'(rom_if.font_addr), 32'h430);
    cycle(11'd0, 11'd0, 12'h000, 1'b0);
    cycle(11'd0, 11'd0, 12'h000, 1'b0);
    check("dir_lit", 32'(rgb_out), 32'hfff);

    cycle(11'd473, 11'd200, 12'h5a5, 1'b0);
    check("dir_font_addr2", 32'(rom_if.font_addr), 32'h430);
    cycle(11'd0, 11'd0, 12'h000, 1'b0);
    cycle(11'd0, 11'd0, 12'h000, 1'b0);
    check("dir_unlit", 32'(rgb_out), 32'h5a5);

    for (int i = 0; i < 400; i++) rnd_cycle(1'b0);

    // 95 steps to the last position, one more to wrap
    wrap_seen = 0;
    frames((SCROLL_MAX - 128 + 1) * SCROLL_DIV);
    check("wrap_count", 32'(wrap_seen), 32'd1);

    frames(50 * SCROLL_DIV);
    for (int i = 0; i < 200; i++) rnd_cycle(1'b0);

    enable = 1'b0;
    for (int i = 0; i < 3; i++) rnd_cycle(1'b0);
    fff_seen = 0;
    for (int i = 0; i < 200; i++) rnd_cycle(1'b0);
    check("drain_no_text", 32'(fff_seen), 32'd0);

    // re-enable: scroll restarts from 0, so the text is hidden again
    enable = 1'b1;
    fff_seen = 0;
    for (int i = 0; i < 200; i++) rnd_cycle(1'b0);
    check("restart_no_text", 32'(fff_seen), 32'd0);

    frames(128 * SCROLL_DIV);
    for (int i = 0; i < 50; i++) rnd_cycle(1'b0);
    rst_n = 1'b0;
    rnd_cycle(1'b0);
    check("mid_rst_rgb", 32'(rgb_out), 32'h0);
    check("mid_rst_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    check("mid_rst_char_xy", 32'(rom_if.char_xy), 32'h0);
    rst_n = 1'b1;
    rnd_cycle(1'b0);
    first_hc = hcount_in;
    rnd_cycle(1'b0);
    rnd_cycle(1'b0);
    check("refill_hcount", 32'(hcount_out), 32'(first_hc));
    for (int i = 0; i < 300; i++) rnd_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
